adder_array_driver: RTL

ADDER_ARRAY_DRIVER -- requirements
Module: adder_array_driver

---
 rtl/adder_array_driver.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/adder_array_driver.sv
// Request/response front end for a 4-lane, 32-bit adder_array: one operation per request, three-state FSM.
// Optional feature macro: ADDER_DRV_STATS_EN (adds saturating stat_ops/stat_ovf counters).
module adder_array_driver (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_lane,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [2:0]  cmd,
  output logic [31:0] ain0,
  output logic [31:0] ain1,
  output logic [31:0] ain2,
  output logic [31:0] ain3,
  output logic [31:0] bin0,
  output logic [31:0] bin1,
  output logic [31:0] bin2,
  output logic [31:0] bin3,
  input  logic [31:0] dout0,
  input  logic [31:0] dout1,
  input  logic [31:0] dout2,
  input  logic [31:0] dout3,
  input  logic [3:0]  overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_ovf,
  output logic [1:0]  rsp_lane
`ifdef ADDER_DRV_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [2:0] CMD_NONE = 3'd4;

  state_t      state_q;
  logic        req_ready_q;
  logic [2:0]  cmd_q;
  logic [1:0]  lane_q;
  logic [31:0] ain_q [4];
  logic [31:0] bin_q [4];
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        rsp_ovf_q;
  logic [1:0]  rsp_lane_q;
  logic [31:0] sel_sum_d;
  logic        sel_ovf_d;

  // Select the active lane's sum; overflow bits are stored in reverse lane order.
  always_comb begin
    sel_sum_d = 32'd0;
    sel_ovf_d = 1'b0;
    case (lane_q)
      2'd0:    begin sel_sum_d = dout0; sel_ovf_d = overflow[3]; end
      2'd1:    begin sel_sum_d = dout1; sel_ovf_d = overflow[2]; end
      2'd2:    begin sel_sum_d = dout2; sel_ovf_d = overflow[1]; end
      2'd3:    begin sel_sum_d = dout3; sel_ovf_d = overflow[0]; end
      default: begin sel_sum_d = 32'd0; sel_ovf_d = 1'b0; end
    endcase
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      cmd_q       <= CMD_NONE;
      lane_q      <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_ovf_q   <= 1'b0;
      rsp_lane_q  <= 2'd0;
      for (int k = 0; k < 4; k++) begin
        ain_q[k] <= 32'd0;
        bin_q[k] <= 32'd0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q          <= ISSUE;
            req_ready_q      <= 1'b0;
            cmd_q            <= {1'b0, req_lane};
            lane_q           <= req_lane;
            ain_q[req_lane]  <= req_a;
            bin_q[req_lane]  <= req_b;
          end
        end
        ISSUE: begin
          state_q     <= RESP;
          cmd_q       <= CMD_NONE;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= sel_sum_d;
          rsp_ovf_q   <= sel_ovf_d;
          rsp_lane_q  <= lane_q;
          for (int k = 0; k < 4; k++) begin
            ain_q[k] <= 32'd0;
            bin_q[k] <= 32'd0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          cmd_q       <= CMD_NONE;
          rsp_valid_q <= 1'b0;
          for (int k = 0; k < 4; k++) begin
            ain_q[k] <= 32'd0;
            bin_q[k] <= 32'd0;
          end
        end
      endcase
    end
  end

`ifdef ADDER_DRV_STATS_EN
  logic [15:0] stat_ops_q;
  logic [15:0] stat_ovf_q;

  // Saturating counts of completed responses and of those flagged overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_ops_q <= 16'd0;
      stat_ovf_q <= 16'd0;
    end else if (rsp_valid_q && rsp_ready) begin
      if (stat_ops_q != 16'hFFFF) stat_ops_q <= stat_ops_q + 16'd1;
      if (rsp_ovf_q && (stat_ovf_q != 16'hFFFF)) stat_ovf_q <= stat_ovf_q + 16'd1;
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_ovf = stat_ovf_q;
`endif

  assign req_ready = req_ready_q;
  assign cmd       = cmd_q;
  assign ain0      = ain_q[0];
  assign ain1      = ain_q[1];
  assign ain2      = ain_q[2];
  assign ain3      = ain_q[3];
  assign bin0      = bin_q[0];
  assign bin1      = bin_q[1];
  assign bin2      = bin_q[2];
  assign bin3      = bin_q[3];
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_lane  = rsp_lane_q;

endmodule
